// File: rtl/multi_chain_config_pkg.sv
// Shared types and CRC helper for the multi-chain configuration manager.
package multi_chain_config_pkg;

  typedef enum logic [2:0] {
    IDLE, RST, FETCH, SHIFT_LO, SHIFT_HI, VERIFY, DONE
  } state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // One MSB-first CRC-16/CCITT step over a single input bit.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/multi_chain_config_manager_phase_gen.sv
// Half-period timer for prog_clk: emits one tick every CLK_HALF_PERIOD enabled
// cycles; the count restarts from zero whenever the enable drops.
module prog_clk_phase_gen #(
  parameter int CLK_HALF_PERIOD = 2048
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic en,
  output logic tick
);
  localparam int CW = (CLK_HALF_PERIOD > 1) ? $clog2(CLK_HALF_PERIOD) : 1;

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(CLK_HALF_PERIOD - 1));

  // Free-running half-period counter, held at zero while disabled.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)      cnt <= '0;
    else if (!en || tick) cnt <= '0;
    else                 cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/multi_chain_config_manager.sv
// Multi-chain CCFF configuration manager: streams one bit per chain per prog_clk
// period into NUM_CHAINS chains. Define CONFIG_VERIFY_EN to add a CRC readback
// pass (ccff_tail input, verify_done/verify_error outputs).
module multi_chain_config_manager
  import multi_chain_config_pkg::*;
#(
  parameter int NUM_CHAINS      = 4,
  parameter int BITSTREAM_LEN   = 1024,
  parameter int CLK_HALF_PERIOD = 2048,
  parameter int RESET_CYCLES    = 3
) (
  input  logic                                  sys_clk,
  input  logic                                  sys_rst_n,
  input  logic                                  start,
  input  logic [NUM_CHAINS-1:0]                 bs_data,
  input  logic                                  bs_valid,
  output logic                                  bs_ready,
  output logic                                  prog_reset,
  output logic                                  prog_clk,
  output logic [NUM_CHAINS-1:0]                 ccff_head,
  output logic                                  busy,
  output logic                                  configuration_done,
  output logic [$clog2(BITSTREAM_LEN+1)-1:0]    bit_count
`ifdef CONFIG_VERIFY_EN
  ,
  input  logic [NUM_CHAINS-1:0]                 ccff_tail,
  output logic                                  verify_done,
  output logic                                  verify_error
`endif
);
  localparam int BCW = $clog2(BITSTREAM_LEN + 1);
  localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  state_t         state, state_nxt;
  logic           tick, clk_en, xfer, bit_last, rst_last;
  logic           in_verify, finish;
  logic [RCW-1:0] rst_cnt;

  assign clk_en   = (state == RST) || (state == SHIFT_LO) || (state == SHIFT_HI);
  assign bs_ready = (state == FETCH) || (state == VERIFY);
  assign xfer     = bs_valid && bs_ready;
  assign bit_last = (bit_count == BCW'(BITSTREAM_LEN - 1));
  assign rst_last = (rst_cnt == RCW'(RESET_CYCLES - 1));

  prog_clk_phase_gen #(.CLK_HALF_PERIOD(CLK_HALF_PERIOD)) u_phase (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .en       (clk_en),
    .tick     (tick)
  );

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next-state logic; a tick while prog_clk is high is a falling edge.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE:    if (start) state_nxt = RST;
      RST:           if (tick && prog_clk && rst_last) state_nxt = FETCH;
      FETCH, VERIFY: if (xfer) state_nxt = SHIFT_LO;
      SHIFT_LO:      if (tick) state_nxt = SHIFT_HI;
      SHIFT_HI: if (tick) begin
`ifdef CONFIG_VERIFY_EN
        if (in_verify) state_nxt = finish ? DONE : VERIFY;
        else           state_nxt = bit_last ? VERIFY : FETCH;
`else
        state_nxt = finish ? DONE : FETCH;
`endif
      end
      default:       state_nxt = IDLE;
    endcase
  end

  // Registered outputs: prog_clk, reset sequencing, head data, progress flags.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      prog_clk           <= 1'b0;
      prog_reset         <= 1'b1;
      ccff_head          <= '0;
      busy               <= 1'b0;
      configuration_done <= 1'b0;
      bit_count          <= '0;
      rst_cnt            <= '0;
    end else begin
      if (!clk_en)   prog_clk <= 1'b0;
      else if (tick) prog_clk <= ~prog_clk;
      case (state)
        IDLE, DONE: if (start) begin
          busy               <= 1'b1;
          prog_reset         <= 1'b1;
          configuration_done <= 1'b0;
          bit_count          <= '0;
          rst_cnt            <= '0;
        end
        RST: if (tick && prog_clk) begin
          if (rst_last) begin
            prog_reset <= 1'b0;
            rst_cnt    <= '0;
          end else begin
            rst_cnt <= rst_cnt + RCW'(1);
          end
        end
        FETCH, VERIFY: if (xfer) ccff_head <= bs_data;
        SHIFT_HI: if (tick) begin
          if (!in_verify && bit_count != BCW'(BITSTREAM_LEN))
            bit_count <= bit_count + BCW'(1);
          if (finish) begin
            configuration_done <= 1'b1;
            busy               <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CONFIG_VERIFY_EN
  logic                         vfy, mism;
  logic [BCW-1:0]               vcnt;
  logic [NUM_CHAINS-1:0][15:0]  crc_load, crc_tail;

  assign in_verify = vfy;
  assign finish    = vfy && (vcnt == BCW'(BITSTREAM_LEN - 1));

  // Any chain whose readback CRC differs from its load CRC.
  always_comb begin
    mism = 1'b0;
    for (int i = 0; i < NUM_CHAINS; i++) mism = mism | (crc_load[i] != crc_tail[i]);
  end

  // Load CRC over accepted head bits; readback CRC over tail bits taken in the
  // cycle just before each rising prog_clk edge of the verify pass.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vfy          <= 1'b0;
      vcnt         <= '0;
      crc_load     <= {NUM_CHAINS{CRC16_INIT}};
      crc_tail     <= {NUM_CHAINS{CRC16_INIT}};
      verify_done  <= 1'b0;
      verify_error <= 1'b0;
    end else begin
      if ((state == IDLE || state == DONE) && start) begin
        vfy          <= 1'b0;
        vcnt         <= '0;
        crc_load     <= {NUM_CHAINS{CRC16_INIT}};
        crc_tail     <= {NUM_CHAINS{CRC16_INIT}};
        verify_done  <= 1'b0;
        verify_error <= 1'b0;
      end
      if (state == FETCH && xfer)
        for (int i = 0; i < NUM_CHAINS; i++) crc_load[i] <= crc16_step(crc_load[i], bs_data[i]);
      if (state == SHIFT_LO && tick && vfy)
        for (int i = 0; i < NUM_CHAINS; i++) crc_tail[i] <= crc16_step(crc_tail[i], ccff_tail[i]);
      if (state == SHIFT_HI && tick) begin
        if (!vfy && bit_last) begin
          vfy  <= 1'b1;
          vcnt <= '0;
        end else if (vfy) begin
          vcnt <= vcnt + BCW'(1);
          if (finish) begin
            verify_done  <= 1'b1;
            verify_error <= mism;
          end
        end
      end
    end
  end
`else
  assign in_verify = 1'b0;
  assign finish    = bit_last;
`endif

endmodule

// File: tb/tb_multi_chain_config_manager.sv
// Directed bench for multi_chain_config_manager with a head-data scoreboard.
module tb_multi_chain_config_manager;
  localparam int N = 4, LEN = 8, HALF = 2, RC = 3, BCW = $clog2(LEN + 1);
`ifdef CONFIG_VERIFY_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif

  logic sys_clk = 1'b0, sys_rst_n = 1'b0, start = 1'b0, bs_valid = 1'b0, u1_start = 1'b0;
  logic [N-1:0]   bs_data = '0, u1_data = 4'h6;
  logic           bs_ready, prog_reset, prog_clk, busy, configuration_done;
  logic [N-1:0]   ccff_head;
  logic [BCW-1:0] bit_count;
  logic           u1_ready, u1_preset, u1_pclk, u1_busy, u1_done;
  logic [N-1:0]   u1_head;
  logic [BCW-1:0] u1_bc;

  logic [N-1:0] pat [LEN];
  logic [N-1:0] exp_q [$];
  int vec = 0, miss = 0;

  always #5 sys_clk = ~sys_clk;

`ifdef CONFIG_VERIFY_EN
  logic [N-1:0] ccff_tail, u1_tail;
  logic         verify_done, verify_error, u1_vd, u1_ve;
  logic [7:0]   sr [N];
  logic         inject = 1'b0;
  assign u1_tail = '0;
  // Chain model: 8-deep shift register per chain clocked by prog_clk.
  always @(posedge prog_clk) for (int i = 0; i < N; i++) sr[i] <= {sr[i][6:0], ccff_head[i]};
  always_comb begin
    ccff_tail = '0;
    for (int i = 0; i < N; i++) ccff_tail[i] = sr[i][7] ^ (inject && i == 0);
  end
`endif

  multi_chain_config_manager #(.NUM_CHAINS(N), .BITSTREAM_LEN(LEN),
    .CLK_HALF_PERIOD(HALF), .RESET_CYCLES(RC)) u0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .bs_data(bs_data),
    .bs_valid(bs_valid), .bs_ready(bs_ready), .prog_reset(prog_reset), .prog_clk(prog_clk),
    .ccff_head(ccff_head), .busy(busy), .configuration_done(configuration_done),
    .bit_count(bit_count)
`ifdef CONFIG_VERIFY_EN
    , .ccff_tail(ccff_tail), .verify_done(verify_done), .verify_error(verify_error)
`endif
  );

  multi_chain_config_manager #(.NUM_CHAINS(N), .BITSTREAM_LEN(LEN),
    .CLK_HALF_PERIOD(1), .RESET_CYCLES(RC)) u1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(u1_start), .bs_data(u1_data),
    .bs_valid(1'b1), .bs_ready(u1_ready), .prog_reset(u1_preset), .prog_clk(u1_pclk),
    .ccff_head(u1_head), .busy(u1_busy), .configuration_done(u1_done),
    .bit_count(u1_bc)
`ifdef CONFIG_VERIFY_EN
    , .ccff_tail(u1_tail), .verify_done(u1_vd), .verify_error(u1_ve)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vec++;
    assert (obs === expv) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge sys_clk);
  endtask

  task automatic do_start();
    start = 1'b1; step(); start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
  endtask

  task automatic wait_rst();
    int rr = 0, n = 0;
    logic prev = prog_clk;
    while (prog_reset && n < 5000) begin
      step();
      if (prog_clk && !prev) rr++;
      prev = prog_clk;
      n++;
    end
    chk("rst_periods", 32'(rr), RC);
    chk("rst_release", 32'(prog_reset), 0);
    chk("rst_release_clk_low", 32'(prog_clk), 0);
  endtask

  task automatic feed_bit(input int k, input int stall, input bit poke, input bit flip);
    int n;
    logic [N-1:0] hold, e;
    logic [BCW-1:0] bc;
    if (stall > 0) begin
      bs_valid = 1'b0;
      for (int s = 0; s < stall; s++) begin
        step();
        chk("stall_clk_low", 32'(prog_clk), 0);
      end
      if (k < LEN) chk("stall_bit_count", 32'(bit_count), 32'(k));
    end
    bs_data = pat[k % LEN];
    bs_valid = 1'b1;
    n = 0;
    while (!bs_ready && n < 1000) begin step(); n++; end
    chk("fetch_ready", 32'(bs_ready), 1);
    exp_q.push_back(bs_data);
    step();
`ifdef CONFIG_VERIFY_EN
    inject = flip;
`endif
    n = 0;
    while (!prog_clk && n < 1000) begin step(); n++; end
`ifdef CONFIG_VERIFY_EN
    inject = 1'b0;
`endif
    chk("rise_seen", 32'(prog_clk), 1);
    e = exp_q.pop_front();
    chk("ccff_head", 32'(ccff_head), 32'(e));
    hold = ccff_head;
    bc = bit_count;
    if (poke) begin
      start = 1'b1; step(); start = 1'b0;
      chk("poke_busy", 32'(busy), 1);
      chk("poke_bit_count", 32'(bit_count), 32'(bc));
    end
    n = 0;
    while (prog_clk && n < 1000) begin
      chk("setup_stable", 32'(ccff_head), 32'(hold));
      step(); n++;
    end
    chk("fall_seen", 32'(prog_clk), 0);
  endtask

  task automatic run_cfg(input int stall_k, input int poke_k, input int flip_k);
    wait_rst();
    for (int k = 0; k < LEN * PASSES; k++)
      feed_bit(k, (k == stall_k) ? 20 : 0, k == poke_k, k == flip_k);
    chk("done_flag", 32'(configuration_done), 1);
    chk("done_busy", 32'(busy), 0);
    chk("done_bit_count", 32'(bit_count), LEN);
    chk("done_prog_reset", 32'(prog_reset), 0);
    chk("done_ready", 32'(bs_ready), 0);
`ifdef CONFIG_VERIFY_EN
    chk("verify_done", 32'(verify_done), 1);
    chk("verify_error", 32'(verify_error), (flip_k >= 0) ? 1 : 0);
`endif
  endtask

  task automatic chk_reset_vals();
    chk("rst_prog_reset", 32'(prog_reset), 1);
    chk("rst_prog_clk", 32'(prog_clk), 0);
    chk("rst_head", 32'(ccff_head), 0);
    chk("rst_ready", 32'(bs_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(configuration_done), 0);
    chk("rst_bit_count", 32'(bit_count), 0);
`ifdef CONFIG_VERIFY_EN
    chk("rst_verify_done", 32'(verify_done), 0);
    chk("rst_verify_error", 32'(verify_error), 0);
`endif
  endtask

  initial begin
    int n, hi, nr;
    logic [7:0] a5;
    for (int k = 0; k < LEN; k++) pat[k] = N'($urandom);
    repeat (3) step();
    chk_reset_vals();
    sys_rst_n = 1'b1;
    step();
    chk("idle_prog_reset", 32'(prog_reset), 1);

    // Baseline load.
    do_start();
    run_cfg(-1, -1, -1);

    // Stall before bit 3 with a fresh pattern.
    for (int k = 0; k < LEN; k++) pat[k] = N'($urandom);
    do_start();
    run_cfg(3, -1, -1);

    // Abort with async reset while bit 4 is being clocked, then reload cleanly.
    do_start();
    wait_rst();
    for (int k = 0; k < 4; k++) feed_bit(k, 0, 1'b0, 1'b0);
    bs_data = pat[4];
    n = 0;
    while (!bs_ready && n < 1000) begin step(); n++; end
    step();
    n = 0;
    while (!prog_clk && n < 1000) begin step(); n++; end
    chk("abort_clk_high", 32'(prog_clk), 1);
    #2 sys_rst_n = 1'b0;
    #1 chk_reset_vals();
    step();
    sys_rst_n = 1'b1;
    step();
    do_start();
    run_cfg(-1, -1, -1);

    // start during SHIFT_HI is ignored; start in DONE restarts.
    do_start();
    run_cfg(-1, 5, -1);
    do_start();
    chk("restart_prog_reset", 32'(prog_reset), 1);
    chk("restart_bit_count", 32'(bit_count), 0);
    chk("restart_done_clr", 32'(configuration_done), 0);
    run_cfg(-1, -1, -1);

    // HALF=1 instance: every high phase lasts exactly one cycle.
    u1_start = 1'b1; step(); u1_start = 1'b0;
    hi = 0; nr = 0; n = 0;
    while (!u1_done && n < 2000) begin
      step(); n++;
      if (u1_pclk) hi++;
      else begin
        if (hi > 0) begin chk("half1_high_width", 32'(hi), 1); nr++; end
        hi = 0;
      end
    end
    chk("half1_done", 32'(u1_done), 1);
    chk("half1_rises", 32'(nr), RC + LEN * PASSES);

`ifdef CONFIG_VERIFY_EN
    // Readback with 0xA5 in every chain, then with one tail bit corrupted.
    a5 = 8'hA5;
    for (int k = 0; k < LEN; k++) pat[k] = {N{a5[7 - k]}};
    do_start();
    run_cfg(-1, -1, -1);
    do_start();
    run_cfg(-1, -1, LEN + 3);
`else
    a5 = 8'h00;
    chk("a5_unused", 32'(a5), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/multi_chain_config_manager.md
Name: multi_chain_config_manager

Overview:
- Parametrised successor to the single-chain FPGA configuration manager.
- Drives NUM_CHAINS configuration flip-flop (CCFF) chains in parallel from one programmable-rate prog_clk.
- Consumes the bitstream through a valid/ready stream, one bit per chain per prog_clk period.
- Supports restartable configuration; optionally verifies the loaded chains by CRC readback.

Parameters:
- NUM_CHAINS, 4: number of parallel CCFF chains (1..32).
- BITSTREAM_LEN, 1024: bits shifted into each chain per configuration (≥1).
- CLK_HALF_PERIOD, 2048: sys_clk cycles per prog_clk phase (≥1).
- RESET_CYCLES, 3: prog_clk periods with prog_reset asserted before shifting (≥1).

Ports:
- sys_clk  in  1  system clock; all state is in this domain.
- sys_rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins configuration from IDLE or DONE.
- bs_data  in  NUM_CHAINS  next bit for each chain (bit i goes to chain i).
- bs_valid  in  1  bs_data valid.
- bs_ready  out  1  accept strobe; transfer when bs_valid && bs_ready.
- prog_reset  out  1  active-high programming reset to the fabric.
- prog_clk  out  1  programming clock, registered.
- ccff_head  out  NUM_CHAINS  chain inputs, registered.
- busy  out  1  high from accepted start until DONE.
- configuration_done  out  1  high in DONE.
- bit_count  out  $clog2(BITSTREAM_LEN+1)  bits shifted so far.

Behaviour:
- Reset values: prog_reset=1, prog_clk=0, ccff_head=0, bs_ready=0, busy=0, configuration_done=0, bit_count=0; state IDLE.
- Phase timer: counts to CLK_HALF_PERIOD-1, then emits a phase tick. prog_clk toggles only on ticks, only in RST and SHIFT_HI/LO. Outside these states prog_clk is held low.
- IDLE: prog_reset=1.
  - On start: busy=1, go to RST.
- RST: prog_reset=1 for RESET_CYCLES full prog_clk periods.
  - prog_reset deasserts on the falling edge that ends the last period. Falling edge means the cycle prog_clk goes 0.
  - Then go to FETCH.
- FETCH: bs_ready=1, prog_clk low.
  - On transfer, register bs_data into ccff_head, set bs_ready=0 the next cycle, go to SHIFT_LO.
  - If bs_valid is low, wait indefinitely with prog_clk held low. This stall is legal and not an error.
- SHIFT_LO: hold low for CLK_HALF_PERIOD cycles. This gives ccff_head setup time. Then go to SHIFT_HI.
- SHIFT_HI: prog_clk=1 for CLK_HALF_PERIOD cycles; the chains sample on this rising edge.
  - On exit, prog_clk returns to 0 and bit_count increments.
  - If bit_count now equals BITSTREAM_LEN, go to DONE; otherwise go to FETCH.
- Per-bit latency: transfer at cycle t → prog_clk rises at t+1+CLK_HALF_PERIOD → falls at t+1+2·CLK_HALF_PERIOD. Minimum bit period is 2·CLK_HALF_PERIOD+1 sys_clk cycles.
- ccff_head changes only while prog_clk is low. It is stable for the whole high phase.
- DONE: configuration_done=1, busy=0, prog_clk=0 (gated), prog_reset=0, ccff_head holds its last value.
  - start in DONE clears bit_count and configuration_done, re-enters RST, and reasserts prog_reset.
- start in any other state than IDLE/DONE is ignored.
- sys_rst_n assertion mid-shift aborts immediately to the reset values. The partial chain content is not recovered.
- bit_count saturates at BITSTREAM_LEN and never wraps.

Optional Feature:
- Macro: CONFIG_VERIFY_EN.
- Defined adds:
  - input ccff_tail[NUM_CHAINS];
  - outputs verify_done, verify_error (both reset 0).
- Defined behaviour:
  - During the load, a per-chain CRC-16 (poly 0x1021, init 0xFFFF, MSB-first) is computed over the ccff_head bits.
  - After BITSTREAM_LEN bits, the controller enters VERIFY. It shifts BITSTREAM_LEN more periods, re-feeding the same stream from the source (bs_ready handshake as in FETCH).
  - In VERIFY, a second CRC is computed over ccff_tail, sampled at each prog_clk rising edge.
  - At the end, verify_done=1. verify_error=1 if any chain's CRCs differ. Then go to DONE.
- Undefined: no VERIFY state; ports are absent.

Decomposition:
- Package multi_chain_config_pkg:
  - state enum: IDLE, RST, FETCH, SHIFT_LO, SHIFT_HI, VERIFY, DONE;
  - CRC16 polynomial and init constants;
  - crc16_step function.
- Sub-module prog_clk_phase_gen: half-period counter and tick generation, parameterised by CLK_HALF_PERIOD, with an enable input.

Test Plan:
- NUM_CHAINS=4, LEN=8, HALF=2, RESET_CYCLES=3, bs_valid tied high, start → prog_reset high for 3 periods. Then 8 prog_clk rising edges, each with ccff_head equal to the supplied nibble. configuration_done rises after the 8th falling edge; bit_count=8.
- Same setup, bs_valid low for 20 cycles before bit 3 → prog_clk stays low with no extra edges. The final chain content is identical; exactly 8 rising edges.
- Assert sys_rst_n low after bit 4 → all outputs return to reset values asynchronously. A following start reloads all 8 bits cleanly.
- start pulsed during SHIFT_HI → ignored; pulsed in DONE → prog_reset reasserts and bit_count=0.
- Check setup on every bit → ccff_head never changes while prog_clk=1; with HALF=1, edges are 1 sys_clk apart.
- CONFIG_VERIFY_EN, 8-bit shift-register model looping head to tail, replaying pattern 0xA5 per chain → verify_error=0. Flip one model bit → verify_error=1.
